// File: rtl/fifo_row_feeder_if.sv
// Handshake bundle between a row FIFO, the tile controller and one fifo_row_feeder.
// master drives launch and FIFO-head signals; slave is the feeder itself.
interface fifo_row_feeder_if #(
    parameter int BWIDTH = 8,
    parameter int LWIDTH = 16
);
    logic              START;
    logic [LWIDTH-1:0] LEN;
    logic              FIFO_EMPTY;
    logic [BWIDTH-1:0] FIFO_DOUT;
    logic              FIFO_POPE;
    logic [BWIDTH-1:0] PE_DATA;
    logic              PE_VALID;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, LEN, FIFO_EMPTY, FIFO_DOUT,
        input  FIFO_POPE, PE_DATA, PE_VALID, BUSY, DONE
    );

    modport slave (
        input  START, LEN, FIFO_EMPTY, FIFO_DOUT,
        output FIFO_POPE, PE_DATA, PE_VALID, BUSY, DONE
    );
endinterface

// File: rtl/fifo_row_feeder.sv
// Read-side feeder for one systolic-array row: skews by ROW_IDX cycles, then streams LEN operands.
// Optional trailing zero pad to flush the array is enabled with FEEDER_ZERO_PAD_EN.
//
// state  | meaning
// IDLE   | waiting for START; DONE pulses from here
// SKEW   | ROW_IDX leading idle cycles for the diagonal wavefront
// STREAM | popping FIFO head onto the PE row, bubbles while FIFO empty
// PAD    | zero operands with PE_VALID=1 until every row lines up (pad build only)
module fifo_row_feeder #(
    parameter int DEPTH   = 32,
    parameter int ROW_IDX = 0,
    parameter int BWIDTH  = 8,
    parameter int LWIDTH  = 16
) (
    input logic              CLK,
    input logic              RST,
    fifo_row_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SKEW,
`ifdef FEEDER_ZERO_PAD_EN
        STREAM,
        PAD
`else
        STREAM
`endif
    } state_t;

    state_t            state;
    logic [LWIDTH-1:0] rem;
    logic [CW-1:0]     skew_cnt;
`ifdef FEEDER_ZERO_PAD_EN
    logic [CW-1:0]     pad_cnt;
`endif
    logic [BWIDTH-1:0] pe_data;
    logic              pe_valid;
    logic              done;
    logic              zero_len_pend;
    logic              pop;

    assign pop           = (state == STREAM) && !bus.FIFO_EMPTY;
    assign bus.FIFO_POPE = pop;
    assign bus.PE_DATA   = pe_data;
    assign bus.PE_VALID  = pe_valid;
    assign bus.BUSY      = (state != IDLE);
    assign bus.DONE      = done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            rem           <= '0;
            skew_cnt      <= '0;
`ifdef FEEDER_ZERO_PAD_EN
            pad_cnt       <= '0;
`endif
            pe_data       <= '0;
            pe_valid      <= 1'b0;
            done          <= 1'b0;
            zero_len_pend <= 1'b0;
        end else begin
            pe_data       <= '0;
            pe_valid      <= 1'b0;
            // a zero-length launch reports completion one edge after START
            done          <= zero_len_pend;
            zero_len_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.LEN == '0) begin
                            zero_len_pend <= 1'b1;
                        end else begin
                            rem <= bus.LEN;
                            if (ROW_IDX > 0) begin
                                state    <= SKEW;
                                skew_cnt <= CW'(ROW_IDX);
                            end else begin
                                state <= STREAM;
                            end
                        end
                    end
                end

                SKEW: begin
                    skew_cnt <= skew_cnt - CW'(1);
                    if (skew_cnt == CW'(1))
                        state <= STREAM;
                end

                STREAM: begin
                    if (pop) begin
                        pe_data  <= bus.FIFO_DOUT;
                        pe_valid <= 1'b1;
                        rem      <= rem - LWIDTH'(1);
                        if (rem == LWIDTH'(1)) begin
`ifdef FEEDER_ZERO_PAD_EN
                            if (ROW_IDX >= DEPTH - 1) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state   <= PAD;
                                pad_cnt <= CW'(DEPTH - 1 - ROW_IDX);
                            end
`else
                            state <= IDLE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end

`ifdef FEEDER_ZERO_PAD_EN
                PAD: begin
                    pe_valid <= 1'b1;
                    pad_cnt  <= pad_cnt - CW'(1);
                    if (pad_cnt == CW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end
endmodule
